// File: rtl/mul_pkg.sv
// mul_pkg: shared Booth multiplier constants and carry-save tree sizing helpers
package mul_pkg;

    localparam int MUL_W = 32;
    localparam int MUL_N = MUL_W / 2 + 1;

    // Rows remaining after lvl levels of 3:2 reduction, starting from rows0
    function automatic int rows_after(input int rows0, input int lvl);
        int r;
        r = rows0;
        for (int i = 0; i < lvl; i++) r = (r / 3) * 2 + r % 3;
        return r;
    endfunction

    // Number of levels needed to reach two rows
    function automatic int num_levels(input int rows0);
        int r;
        int l;
        r = rows0;
        l = 0;
        while (r > 2) begin
            r = (r / 3) * 2 + r % 3;
            l++;
        end
        return l;
    endfunction

    // Level after which the optional mid register sits, splitting the tree roughly in half
    function automatic int mid_level(input int rows0);
        return (num_levels(rows0) + 1) / 2;
    endfunction

endpackage

// File: rtl/csa_3_2.sv
// csa_3_2: one row of 3:2 carry-save adders; carry already shifted into its weight
module csa_3_2 #(
    parameter int WD = 64
) (
    input  logic [WD-1:0] a,
    input  logic [WD-1:0] b,
    input  logic [WD-1:0] c,
    output logic [WD-1:0] s,
    output logic [WD-1:0] co
);

    assign s  = a ^ b ^ c;
    assign co = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/wallace_csa_pipe.sv
// wallace_csa_pipe: pipelined Booth partial-product CSA reduction to sum/carry (WALLACE_MID_REG_EN adds a mid-tree register)
module wallace_csa_pipe
    import mul_pkg::*;
#(
    parameter int W = MUL_W,
    parameter int N = W / 2 + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [N*2*W-1:0]  io_pp,
    input  logic [N-1:0]      io_neg,
    input  logic              io_flush,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [2*W-1:0]    io_sum,
    output logic [2*W-1:0]    io_carry
);

    localparam int DW = 2 * W;
    localparam int R0 = N + 1;
    localparam int L  = num_levels(R0);
    localparam int M  = mid_level(R0);
    localparam int RM = rows_after(R0, M);

    logic [DW-1:0] lv [L+1][R0];
    logic [DW-1:0] mid_src [RM];
    logic [DW-1:0] corr;

    // Correction row supplies the +1 of each negated row at weight 2^(2i)
    always_comb begin
        corr = '0;
        for (int i = 0; i < N; i++) corr[2*i] = io_neg[i];
    end

    for (genvar i = 0; i < N; i++) begin : g_in
        assign lv[0][i] = io_pp[DW*i +: DW];
    end
    assign lv[0][N] = corr;

    // Reduction tree; level M+1 reads mid_src so the mid register can be spliced in
    for (genvar l = 1; l <= L; l++) begin : g_lvl
        localparam int RI = rows_after(R0, l - 1);
        localparam int RO = rows_after(R0, l);
        localparam int G  = RI / 3;
        for (genvar j = 0; j < G; j++) begin : g_csa
            if (l == M + 1) begin : g_m
                csa_3_2 #(.WD(DW)) u_csa (
                    .a (mid_src[3*j]),
                    .b (mid_src[3*j+1]),
                    .c (mid_src[3*j+2]),
                    .s (lv[l][2*j]),
                    .co(lv[l][2*j+1])
                );
            end else begin : g_t
                csa_3_2 #(.WD(DW)) u_csa (
                    .a (lv[l-1][3*j]),
                    .b (lv[l-1][3*j+1]),
                    .c (lv[l-1][3*j+2]),
                    .s (lv[l][2*j]),
                    .co(lv[l][2*j+1])
                );
            end
        end
        for (genvar j = 2 * G; j < R0; j++) begin : g_pass
            if (j < RO) begin : g_p
                if (l == M + 1) begin : g_m
                    assign lv[l][j] = mid_src[G+j];
                end else begin : g_t
                    assign lv[l][j] = lv[l-1][G+j];
                end
            end else begin : g_z
                assign lv[l][j] = '0;
            end
        end
    end

    logic          out_v_q, out_v_d, out_ld, upd;
    logic [DW-1:0] sum_q, carry_q;

`ifdef WALLACE_MID_REG_EN
    logic          mid_v_q, mid_v_d, mid_ld, acc;
    logic [DW-1:0] mid_q [RM];

    for (genvar k = 0; k < RM; k++) begin : g_mid
        assign mid_src[k] = mid_q[k];
    end

    // Two-stage handshake: each register loads when empty or draining; flush empties both
    always_comb begin
        out_ld      = !out_v_q || io_out_ready;
        mid_ld      = !mid_v_q || out_ld;
        io_in_ready = io_flush || mid_ld;
        acc         = io_in_valid && mid_ld && !io_flush;
        upd         = mid_v_q && out_ld && !io_flush;
        mid_v_d     = io_flush ? 1'b0 : mid_ld ? io_in_valid : mid_v_q;
        out_v_d     = io_flush ? 1'b0 : out_ld ? mid_v_q : out_v_q;
    end

    // Mid register captures the partially reduced rows
    always_ff @(posedge clock) begin
        if (reset) begin
            mid_v_q <= 1'b0;
        end else begin
            mid_v_q <= mid_v_d;
            if (acc) for (int k = 0; k < RM; k++) mid_q[k] <= lv[M][k];
        end
    end
`else
    for (genvar k = 0; k < RM; k++) begin : g_mid
        assign mid_src[k] = lv[M][k];
    end

    // Single-stage handshake: output register loads when empty or draining; flush empties it
    always_comb begin
        out_ld      = !out_v_q || io_out_ready;
        io_in_ready = io_flush || out_ld;
        upd         = io_in_valid && out_ld && !io_flush;
        out_v_d     = io_flush ? 1'b0 : out_ld ? io_in_valid : out_v_q;
    end
`endif

    // Output register holds sum/carry stable until the consumer takes them
    always_ff @(posedge clock) begin
        if (reset) begin
            out_v_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            out_v_q <= out_v_d;
            if (upd) begin
                sum_q   <= lv[L][0];
                carry_q <= lv[L][1];
            end
        end
    end

    assign io_out_valid = out_v_q;
    assign io_sum       = sum_q;
    assign io_carry     = carry_q;

endmodule

// File: doc/wallace_csa_pipe.md
# wallace_csa_pipe

Pipelined carry-save reduction stage of the radix-4 Booth multiplier. It sits directly downstream of the per-bit partial-product generator array. It accepts the N = W/2+1 Booth partial-product rows plus their per-row negate flags, and compresses them through a tree of 3:2 carry-save adders into one sum word and one carry word. Those two words are handed to the final carry-propagate adder under a valid/ready handshake.

## Interface
Parameters:
- W, 32, operand width in bits; must be even.
- N, W/2+1, number of Booth partial-product rows.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous and active-high
- io_in_valid  in  1  partial-product set valid
- io_in_ready  out  1  stage can accept a set this cycle
- io_pp  in  N*2W  row i occupies bits [2W*i +: 2W]; already shifted left by 2i and sign-extended to 2W bits
- io_neg  in  N  bit i set when row i was generated with a negative select (needs +1 at bit 2i)
- io_flush  in  1  kill all in-flight sets (pipeline flush)
- io_out_valid  out  1  sum/carry valid
- io_out_ready  in  1  consumer accepts sum/carry
- io_sum  out  2W  carry-save sum word
- io_carry  out  2W  carry-save carry word, already shifted into its weight

## Operation
- Correction row: an extra row R_N is built with bit 2i = io_neg[i] and all other bits 0. The tree therefore reduces N+1 rows. With W=32 that is 18 rows.
- Reduction: each level groups rows in threes. Each group of three produces a 3:2 CSA sum row and a carry row; the carry row is shifted left by 1 and truncated to 2W bits. Leftover rows (1 or 2) pass through unchanged. Levels repeat until 2 rows remain.
  - For W=32 the row counts per level are 18→12→8→6→4→3→2.
- Invariant: (io_sum + io_carry) mod 2^2W = (Σ io_pp rows + Σ io_neg[i]·2^(2i)) mod 2^2W. This equals the signed product of the Booth operands.
- All arithmetic is modulo 2^2W. Bits shifted out above bit 2W-1 are dropped.
- Handshake per pipeline register:
  - A register loads when it is empty or its contents are leaving this cycle.
  - io_in_ready = !first_reg_valid || first_reg_advances. This is combinational from io_out_ready; no skid buffer is used.
  - io_out_valid stays asserted and io_sum/io_carry are held stable until io_out_ready is high.
- Flush: io_flush clears every valid bit next cycle and takes priority over a simultaneous accept. A set presented with io_in_valid in the flush cycle is dropped, and io_in_ready reads 1 during flush. Data registers are not cleared by flush.
- Reset: all valid bits go to 0, and io_sum and io_carry go to 0. A reset mid-operation discards in-flight sets. io_in_ready reads 1 in the first cycle after reset deasserts.

## Timing
- Latency without mid register: 1 cycle. The set accepted at edge k is on io_out_valid after edge k.
- Latency with mid register: 2 cycles.
- Throughput: one set per cycle while io_out_ready=1.
- When full with io_out_ready=0: io_in_ready=0. When io_out_ready=1 in that same cycle, input accept and output drain happen on the same edge.
- The combinational tree depth between registers is at most 3 CSA levels when the mid register is present.

## Configuration
- WALLACE_MID_REG_EN defined:
  - Adds a pipeline register (rows plus valid) after reduction level 3, which is 6 rows for W=32. Latency is 2.
  - Both registers obey the handshake and flush rules above.
- WALLACE_MID_REG_EN undefined:
  - A single output register follows the full tree. Latency is 1.
- Functional results are identical in both builds.

## Structure
- Shared package mul_pkg:
  - constants MUL_W=32 and MUL_N=17
  - a function giving the row count after each reduction level
  - a function giving the level index where the mid register is placed
- Sub-module csa_3_2, parameterized by width: takes inputs a, b, c and produces s = a^b^c and co = maj(a,b,c) shifted left by 1 and truncated.
- The tree is built from generate loops over csa_3_2 instances.

## Test plan
- Single row: pp0=5, other rows 0, io_neg=0 → io_sum+io_carry = 5, io_out_valid one cycle later (two with the macro).
- Booth product: rows and negate flags from a bench Booth model of 3 × -7 → io_sum+io_carry = 0xFFFF_FFFF_FFFF_FFEB.
- Extremes: 0x8000_0000 × 0x8000_0000 → 0x4000_0000_0000_0000. 0xFFFF_FFFF × 0xFFFF_FFFF (signed -1 × -1) → 1.
- Backpressure: stream 4 random sets with io_out_ready held 0 for 5 cycles → io_in_ready=0 once full, outputs stable, then all 4 results emerge in order with none lost or duplicated.
- Flush: assert io_flush with a set valid at io_in_valid and a set in flight → io_out_valid=0 next cycle, neither result ever appears, and the next set is accepted normally.
- Reset mid-stream: pulse reset while io_out_valid=1 → io_out_valid=0, io_sum=io_carry=0, io_in_ready=1 in the first cycle after reset deasserts.
